// File: rtl/fib_arbiter_pkg.sv
// fib_arbiter_pkg: shared types and helpers for the fib core arbiter.
//   - fib_arb_state_e : arbiter FSM states
//   - FIB_DATA_W      : default argument/result width of the fib core
//   - grant_idx_w()   : width of a grant index for a given requester count
package fib_arbiter_pkg;

  localparam int FIB_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACCEPT  = 3'd3,
    ST_RESPOND = 3'd4
  } fib_arb_state_e;

  // Never return 0 so that a 1-bit index exists even for degenerate counts.
  function automatic int grant_idx_w(input int num_req);
    int w;
    w = $clog2(num_req);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin selector.
// Searches req_valid starting at last_grant+1 and wrapping, returning the
// first pending requester.
// Ports:
//   req_valid  in  NUM_REQ  pending request bits
//   last_grant in  IDX_W    index granted most recently
//   grant_oh   out NUM_REQ  one-hot selected requester (0 if none)
//   grant_idx  out IDX_W    index of the selected requester
//   any_req    out 1        at least one request pending
module rr_priority_picker
  import fib_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = grant_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic             hit_s;
  logic [IDX_W-1:0] pos_s;

  // Rotating first-set-bit search; offset NUM_REQ lands back on last_grant
  // so a lone repeat requester is still found.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    hit_s     = 1'b0;
    pos_s     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos_s = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!hit_s && req_valid[pos_s]) begin
        hit_s           = 1'b1;
        grant_idx       = pos_s;
        grant_oh[pos_s] = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign any_req = |req_valid;

endmodule

// File: rtl/fib_arbiter.sv
// fib_arbiter: round-robin controller sharing one fib core among NUM_REQ
// requesters. Takes n from the granted requester, runs the core's
// ready/valid/accept handshake and returns the result to that requester.
// Optional feature macro: FIB_ARBITER_TIMEOUT_EN (WAIT watchdog, rsp_err).
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   req_valid, req_n  requester side: pending bits and packed arguments
//   req_ready         one-hot 1-cycle pulse: request taken
//   rsp_valid         one-hot: result available for that requester
//   rsp_data, rsp_err result and timeout flag
//   rsp_accept        requester consumes its result
//   busy              high in every state except IDLE
//   fib_ready, fib_in_n, fib_accept  drive the core
//   fib_valid, fib_out_0             core result
module fib_arbiter
  import fib_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = FIB_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_n,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic [NUM_REQ-1:0]        rsp_accept,
  output logic                      busy,
  output logic                      fib_ready,
  output logic [DATA_W-1:0]         fib_in_n,
  input  logic                      fib_valid,
  input  logic [DATA_W-1:0]         fib_out_0,
  output logic                      fib_accept
);

  localparam int IDX_W = grant_idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  fib_arb_state_e      state_r, state_nx;
  logic [IDX_W-1:0]    grant_r, grant_nx;
  logic [IDX_W-1:0]    last_grant_r, last_grant_nx;
  logic [DATA_W-1:0]   result_r, result_nx;
  logic [NUM_REQ-1:0]  req_ready_r, req_ready_nx;
  logic [NUM_REQ-1:0]  rsp_valid_r, rsp_valid_nx;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_nx;
  logic                busy_r, busy_nx;
  logic                fib_ready_r, fib_ready_nx;
  logic [DATA_W-1:0]   fib_in_n_r, fib_in_n_nx;
  logic                fib_accept_r, fib_accept_nx;

  logic [NUM_REQ-1:0]  pick_oh_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_any_s;
  logic [DATA_W-1:0]   n_sel_s;
  logic [NUM_REQ-1:0]  grant_oh_s;

`ifdef FIB_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    tmo_cnt_r, tmo_cnt_nx;
  logic                rsp_err_r, rsp_err_nx;
`endif

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant_r),
    .grant_oh   (pick_oh_s),
    .grant_idx  (pick_idx_s),
    .any_req    (pick_any_s)
  );

  // Argument of the requester the picker currently selects.
  always_comb begin
    n_sel_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_sel_s = (pick_idx_s == IDX_W'(i)) ? req_n[i*DATA_W +: DATA_W] : n_sel_s;
    end
  end

  assign grant_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_nx      = state_r;
    grant_nx      = grant_r;
    last_grant_nx = last_grant_r;
    result_nx     = result_r;
    req_ready_nx  = '0;
    fib_ready_nx  = 1'b0;
    fib_accept_nx = 1'b0;
    fib_in_n_nx   = fib_in_n_r;
    rsp_valid_nx  = rsp_valid_r;
    rsp_data_nx   = rsp_data_r;
`ifdef FIB_ARBITER_TIMEOUT_EN
    tmo_cnt_nx    = tmo_cnt_r;
    rsp_err_nx    = rsp_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_nx     = pick_idx_s;
          fib_in_n_nx  = n_sel_s;
          req_ready_nx = pick_oh_s;
          fib_ready_nx = 1'b1;
          state_nx     = ST_START;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        state_nx = ST_WAIT;
`ifdef FIB_ARBITER_TIMEOUT_EN
        tmo_cnt_nx = '0;
`endif
      end
      ST_WAIT: begin
        // A result arriving in the expiry cycle takes the normal path.
        if (fib_valid) begin
          result_nx     = fib_out_0;
          fib_accept_nx = 1'b1;
          state_nx      = ST_ACCEPT;
        end else begin
`ifdef FIB_ARBITER_TIMEOUT_EN
          if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_nx = grant_oh_s;
            rsp_data_nx  = '0;
            rsp_err_nx   = 1'b1;
            state_nx     = ST_RESPOND;
          end else begin
            tmo_cnt_nx = tmo_cnt_r + TMO_W'(1);
          end
`else
          state_nx = ST_WAIT;
`endif
        end
      end
      ST_ACCEPT: begin
        rsp_valid_nx = grant_oh_s;
        rsp_data_nx  = result_r;
        state_nx     = ST_RESPOND;
      end
      ST_RESPOND: begin
        // Only the granted requester's accept bit matters.
        if (rsp_accept[grant_r]) begin
          rsp_valid_nx  = '0;
          rsp_data_nx   = '0;
          fib_in_n_nx   = '0;
          last_grant_nx = grant_r;
          state_nx      = ST_IDLE;
`ifdef FIB_ARBITER_TIMEOUT_EN
          rsp_err_nx    = 1'b0;
`endif
        end else begin
          state_nx = ST_RESPOND;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  // State, context and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= '0;
      last_grant_r <= LAST_INIT;
      result_r     <= '0;
      req_ready_r  <= '0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
      busy_r       <= 1'b0;
      fib_ready_r  <= 1'b0;
      fib_in_n_r   <= '0;
      fib_accept_r <= 1'b0;
`ifdef FIB_ARBITER_TIMEOUT_EN
      tmo_cnt_r    <= '0;
      rsp_err_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_nx;
      grant_r      <= grant_nx;
      last_grant_r <= last_grant_nx;
      result_r     <= result_nx;
      req_ready_r  <= req_ready_nx;
      rsp_valid_r  <= rsp_valid_nx;
      rsp_data_r   <= rsp_data_nx;
      busy_r       <= busy_nx;
      fib_ready_r  <= fib_ready_nx;
      fib_in_n_r   <= fib_in_n_nx;
      fib_accept_r <= fib_accept_nx;
`ifdef FIB_ARBITER_TIMEOUT_EN
      tmo_cnt_r    <= tmo_cnt_nx;
      rsp_err_r    <= rsp_err_nx;
`endif
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign busy       = busy_r;
  assign fib_ready  = fib_ready_r;
  assign fib_in_n   = fib_in_n_r;
  assign fib_accept = fib_accept_r;
`ifdef FIB_ARBITER_TIMEOUT_EN
  assign rsp_err    = rsp_err_r;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
